// File: rtl/m_store_buffer_pkg.sv
// Shared definitions for the MEM-stage store buffer: store op codes, the data-bus
// address map and the queued entry layout.
package m_store_buffer_pkg;

    localparam logic [1:0] ST_SW = 2'd0;
    localparam logic [1:0] ST_SH = 2'd1;
    localparam logic [1:0] ST_SB = 2'd2;

    localparam logic [31:0] DM_BEGIN        = 32'h0000_0000;
    localparam logic [31:0] DM_END          = 32'h0000_2FFF;
    localparam logic [31:0] TC1_BEGIN       = 32'h0000_7F00;
    localparam logic [31:0] TC1_END         = 32'h0000_7F0B;
    localparam logic [31:0] TC2_BEGIN       = 32'h0000_7F10;
    localparam logic [31:0] TC2_END         = 32'h0000_7F1B;
    localparam logic [31:0] TC_COUNT_OFFSET = 32'h0000_0008;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  byteen;
        logic [31:0] pc;
    } sb_entry_t;

    function automatic logic in_range(input logic [31:0] a, input logic [31:0] lo,
                                      input logic [31:0] hi);
        return (a >= lo) && (a <= hi);
    endfunction

endpackage

// File: rtl/m_store_encode.sv
// Store encoder: byte enables, lane-replicated write data and AdES screening.
// Optional macro SB_COUNT_PROTECT_EN makes timer count registers store-protected.
module m_store_encode
    import m_store_buffer_pkg::*;
(
    input  logic        check,
    input  logic [1:0]  st_op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        exc_ov,
    output logic [3:0]  byteen,
    output logic [31:0] data,
    output logic        ades
);

    logic word_op;
    logic misalign;
    logic in_dm;
    logic in_tc;
    logic count_hit;

    always_comb begin
        byteen   = 4'b1111;
        data     = wdata;
        word_op  = 1'b1;
        misalign = addr[1:0] != 2'b00;
        case (st_op)
            ST_SH: begin
                byteen   = addr[1] ? 4'b1100 : 4'b0011;
                data     = {2{wdata[15:0]}};
                word_op  = 1'b0;
                misalign = addr[0];
            end
            ST_SB: begin
                byteen   = 4'b0001 << addr[1:0];
                data     = {4{wdata[7:0]}};
                word_op  = 1'b0;
                misalign = 1'b0;
            end
            default: ;  // SW and the reserved code behave as SW
        endcase
    end

    assign in_dm = in_range(addr, DM_BEGIN, DM_END);
    assign in_tc = in_range(addr, TC1_BEGIN, TC1_END) | in_range(addr, TC2_BEGIN, TC2_END);

`ifdef SB_COUNT_PROTECT_EN
    assign count_hit = in_range(addr, TC1_BEGIN + TC_COUNT_OFFSET, TC1_END)
                     | in_range(addr, TC2_BEGIN + TC_COUNT_OFFSET, TC2_END);
`else
    assign count_hit = 1'b0;
`endif

    assign ades = check & (misalign | ~(in_dm | in_tc) | (~word_op & in_tc) | exc_ov | count_hit);

endmodule

// File: rtl/m_store_buffer.sv
// MEM-stage store buffer: encodes and screens stores, queues them in a FIFO that drains
// over a valid/ready bus, and flags loads hitting a queued word. See m_store_encode.
module m_store_buffer
    import m_store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        store,
    input  logic [1:0]  st_op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] pc,
    input  logic        exc_ov,
    input  logic        flush,
    output logic        req_ready,
    output logic        exc_ades,
    input  logic        ld_valid,
    input  logic [31:0] ld_addr,
    output logic        ld_stall,
    output logic        m_data_valid,
    input  logic        m_data_ready,
    output logic [31:0] m_data_addr,
    output logic [31:0] m_data_wdata,
    output logic [3:0]  m_data_byteen,
    output logic [31:0] m_inst_addr,
    output logic        empty
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0] FullCount = (PtrW + 1)'(DEPTH);

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]   count_q, count_d;
    sb_entry_t       mem_q [DEPTH];
    sb_entry_t       new_entry, head;
    logic [3:0]      enc_byteen;
    logic [31:0]     enc_data;
    logic            enq, deq;
    logic [PtrW-1:0] offset;

    m_store_encode u_encode (
        .check  (req_valid & store),
        .st_op  (st_op),
        .addr   (addr),
        .wdata  (wdata),
        .exc_ov (exc_ov),
        .byteen (enc_byteen),
        .data   (enc_data),
        .ades   (exc_ades)
    );

    assign empty        = count_q == '0;
    assign req_ready    = count_q != FullCount;
    assign m_data_valid = ~empty;
    assign enq          = req_valid & store & req_ready & ~exc_ades & ~flush;
    assign deq          = m_data_valid & m_data_ready;

    assign new_entry = '{addr: {addr[31:2], 2'b00}, data: enc_data, byteen: enc_byteen, pc: pc};

    always_comb begin
        wr_ptr_d = enq ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = deq ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({enq, deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (enq) mem_q[wr_ptr_q] <= new_entry;
        end
    end

    // An entry is live when its distance from the read pointer is below the count.
    always_comb begin
        ld_stall = 1'b0;
        offset   = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            offset = PtrW'(i) - rd_ptr_q;
            if (({1'b0, offset} < count_q) && (mem_q[i].addr[31:2] == ld_addr[31:2])) begin
                ld_stall = ld_valid;
            end
        end
    end

    assign head          = mem_q[rd_ptr_q];
    assign m_data_addr   = m_data_valid ? head.addr : '0;
    assign m_data_wdata  = m_data_valid ? head.data : '0;
    assign m_data_byteen = m_data_valid ? head.byteen : '0;
    assign m_inst_addr   = m_data_valid ? head.pc : '0;

endmodule

// File: tb/tb_m_store_buffer.sv
// Scoreboard bench for m_store_buffer: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_m_store_buffer;

    localparam int unsigned DEPTH = 2;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, store = 1'b0, exc_ov = 1'b0, flush = 1'b0;
    logic [1:0]  st_op = 2'd0;
    logic [31:0] addr = '0, wdata = '0, pc = '0, ld_addr = '0;
    logic        ld_valid = 1'b0, m_data_ready = 1'b0;
    logic        req_ready, exc_ades, ld_stall, m_data_valid, empty;
    logic [31:0] m_data_addr, m_data_wdata, m_inst_addr;
    logic [3:0]  m_data_byteen;

    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    exp_t exp_q[$];
    exp_t pend;
    bit   pend_valid = 1'b0;

    always #5 clk = ~clk;

    m_store_buffer #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .store         (store),
        .st_op         (st_op),
        .addr          (addr),
        .wdata         (wdata),
        .pc            (pc),
        .exc_ov        (exc_ov),
        .flush         (flush),
        .req_ready     (req_ready),
        .exc_ades      (exc_ades),
        .ld_valid      (ld_valid),
        .ld_addr       (ld_addr),
        .ld_stall      (ld_stall),
        .m_data_valid  (m_data_valid),
        .m_data_ready  (m_data_ready),
        .m_data_addr   (m_data_addr),
        .m_data_wdata  (m_data_wdata),
        .m_data_byteen (m_data_byteen),
        .m_inst_addr   (m_inst_addr),
        .empty         (empty)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference rules written directly from the address map and store-type table.
    function automatic bit model_ades(input logic [1:0] op, input logic [31:0] a, input bit ov);
        bit is_word, is_half, in_dm, in_tc, mis, cnt;
        is_word = (op == 2'd0) || (op == 2'd3);
        is_half = (op == 2'd1);
        in_dm   = a <= 32'h2FFF;
        in_tc   = (a >= 32'h7F00 && a <= 32'h7F0B) || (a >= 32'h7F10 && a <= 32'h7F1B);
        cnt     = (a >= 32'h7F08 && a <= 32'h7F0B) || (a >= 32'h7F18 && a <= 32'h7F1B);
        mis     = is_word ? (a % 4 != 0) : (is_half ? (a % 2 != 0) : 1'b0);
`ifndef SB_COUNT_PROTECT_EN
        cnt = 1'b0;
`endif
        return mis || !(in_dm || in_tc) || (!is_word && in_tc) || ov || cnt;
    endfunction

    function automatic exp_t model_encode(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] wd, input logic [31:0] p);
        exp_t e;
        e.addr = a - (a % 4);
        e.pc   = p;
        if (op == 2'd1) begin
            e.be   = (a % 4 >= 2) ? 4'b1100 : 4'b0011;
            e.data = {wd[15:0], wd[15:0]};
        end else if (op == 2'd2) begin
            e.be   = 4'(1 << (a % 4));
            e.data = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
        end else begin
            e.be   = 4'hF;
            e.data = wd;
        end
        return e;
    endfunction

    task automatic drive(input bit v, input bit st, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] p, input bit ov, input bit fl,
                         input bit ldv, input logic [31:0] la, input bit rdy);
        bit exp_ades, exp_stall;
        @(posedge clk);
        if (pend_valid) begin
            exp_q.push_back(pend);
            pend_valid = 1'b0;
        end
        #1;
        req_valid = v; store = st; st_op = op; addr = a; wdata = wd; pc = p;
        exc_ov = ov; flush = fl; ld_valid = ldv; ld_addr = la; m_data_ready = rdy;
        #1;
        exp_ades = v && st && model_ades(op, a, ov);
        exp_stall = 1'b0;
        foreach (exp_q[i]) if (exp_q[i].addr / 4 == la / 4) exp_stall = ldv;
        chk("exc_ades", 32'(exc_ades), 32'(exp_ades));
        chk("req_ready", 32'(req_ready), 32'(exp_q.size() < DEPTH));
        chk("ld_stall", 32'(ld_stall), 32'(exp_stall));
        if (v && st && !exp_ades && !fl && exp_q.size() < DEPTH) begin
            pend       = model_encode(op, a, wd, p);
            pend_valid = 1'b1;
        end
    endtask

    task automatic idle(input bit rdy);
        drive(0, 0, 2'd0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 32'h0, rdy);
    endtask

    // Monitor: compares the bus head against the scoreboard and retires on handshake.
    always @(negedge clk) begin
        if (!reset && mon_en) begin
            chk("m_data_valid", 32'(m_data_valid), 32'(exp_q.size() != 0));
            chk("empty", 32'(empty), 32'(exp_q.size() == 0));
            if (exp_q.size() != 0) begin
                chk("head_addr", m_data_addr, exp_q[0].addr);
                chk("head_wdata", m_data_wdata, exp_q[0].data);
                chk("head_byteen", 32'(m_data_byteen), 32'(exp_q[0].be));
                chk("head_pc", m_inst_addr, exp_q[0].pc);
                if (m_data_valid && m_data_ready) void'(exp_q.pop_front());
            end else begin
                chk("idle_outputs", m_data_addr | m_data_wdata | m_inst_addr
                    | 32'(m_data_byteen), 32'h0);
            end
        end
    end

    initial begin
        logic [31:0] ra, rla;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_empty", 32'(empty), 32'h1);
        chk("rst_req_ready", 32'(req_ready), 32'h1);
        chk("rst_valid", 32'(m_data_valid), 32'h0);
        chk("rst_outputs", m_data_addr | m_data_wdata | m_inst_addr | 32'(m_data_byteen), 32'h0);
        @(negedge clk);
        reset  = 1'b0;
        mon_en = 1'b1;

        // SB to 0x13 with bus ready
        drive(1, 1, 2'd2, 32'h13, 32'h1234_56AB, 32'h0040_0000, 0, 0, 0, 32'h0, 1);
        idle(1);
        chk("sb_byteen", 32'(m_data_byteen), 32'h8);
        chk("sb_wdata", m_data_wdata, 32'hABAB_ABAB);
        chk("sb_addr", m_data_addr, 32'h10);
        idle(1);

        // Address errors
        drive(1, 1, 2'd1, 32'h5, 32'h1, 32'h100, 0, 0, 0, 32'h0, 1);
        chk("sh_mis_ades", 32'(exc_ades), 32'h1);
        drive(1, 1, 2'd1, 32'h7F04, 32'h1, 32'h104, 0, 0, 0, 32'h0, 1);
        chk("sh_tc_ades", 32'(exc_ades), 32'h1);
        drive(1, 1, 2'd0, 32'h3000, 32'h1, 32'h108, 0, 0, 0, 32'h0, 1);
        chk("sw_oob_ades", 32'(exc_ades), 32'h1);
        idle(1);
        chk("ades_no_enq", 32'(empty), 32'h1);

        // Fill with bus stalled, then drain
        drive(1, 1, 2'd0, 32'h0, 32'hA0, 32'h200, 0, 0, 0, 32'h0, 0);
        drive(1, 1, 2'd0, 32'h4, 32'hA4, 32'h204, 0, 0, 0, 32'h0, 0);
        drive(1, 1, 2'd0, 32'h8, 32'hA8, 32'h208, 0, 0, 0, 32'h0, 0);
        chk("full_req_ready", 32'(req_ready), 32'h0);
        drive(1, 1, 2'd0, 32'h8, 32'hA8, 32'h208, 0, 0, 0, 32'h0, 0);
        chk("stall_hold_addr", m_data_addr, 32'h0);
        drive(1, 1, 2'd0, 32'h8, 32'hA8, 32'h208, 0, 0, 0, 32'h0, 1);
        chk("full_deq_no_enq", 32'(req_ready), 32'h0);
        drive(1, 1, 2'd0, 32'h8, 32'hA8, 32'h208, 0, 0, 0, 32'h0, 1);
        chk("after_deq_ready", 32'(req_ready), 32'h1);
        repeat (4) idle(1);

        // Load hazard
        drive(1, 1, 2'd0, 32'h104, 32'h55, 32'h300, 0, 0, 0, 32'h0, 0);
        drive(0, 0, 2'd0, 32'h0, 32'h0, 32'h0, 0, 0, 1, 32'h106, 0);
        chk("ld_hit", 32'(ld_stall), 32'h1);
        drive(0, 0, 2'd0, 32'h0, 32'h0, 32'h0, 0, 0, 1, 32'h108, 0);
        chk("ld_miss", 32'(ld_stall), 32'h0);
        repeat (3) idle(1);

        // Timer count register
        drive(1, 1, 2'd0, 32'h7F08, 32'h77, 32'h400, 0, 0, 0, 32'h0, 1);
`ifdef SB_COUNT_PROTECT_EN
        chk("tc_count_ades", 32'(exc_ades), 32'h1);
`else
        chk("tc_count_ades", 32'(exc_ades), 32'h0);
`endif
        repeat (3) idle(1);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 5))
                0, 1:    ra = $urandom_range(0, 63);
                2:       ra = 32'h7F00 + $urandom_range(0, 31);
                3:       ra = $urandom_range(0, 32'h2FFF) & 32'hFFFF_FFFC;
                4:       ra = 32'h2FF8 + $urandom_range(0, 15);
                default: ra = $urandom;
            endcase
            rla = $urandom_range(0, 63);
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) != 0),
                  2'($urandom_range(0, 3)), ra, $urandom, $urandom,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 9) == 0,
                  1'($urandom_range(0, 1)), rla, 1'($urandom_range(0, 2) != 0));
        end
        repeat (DEPTH + 3) idle(1);
        chk("final_empty", 32'(empty), 32'h1);

        // Reset while the head is presented
        drive(1, 1, 2'd0, 32'h20, 32'h11, 32'h500, 0, 0, 0, 32'h0, 0);
        drive(1, 1, 2'd0, 32'h24, 32'h22, 32'h504, 0, 0, 0, 32'h0, 0);
        idle(0);
        chk("pre_rst_valid", 32'(m_data_valid), 32'h1);
        @(negedge clk);
        #2;
        mon_en = 1'b0;
        reset  = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(m_data_valid), 32'h0);
        chk("mid_rst_empty", 32'(empty), 32'h1);
        chk("mid_rst_ready", 32'(req_ready), 32'h1);
        chk("mid_rst_outputs", m_data_addr | m_data_wdata | m_inst_addr | 32'(m_data_byteen),
            32'h0);
        exp_q.delete();
        pend_valid = 1'b0;
        @(negedge clk);
        reset  = 1'b0;
        mon_en = 1'b1;
        repeat (2) idle(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
